// File: rtl/exc_pkg.sv
// Shared types and cause codes for the LEGv8 exception/interrupt controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    FAULT   = 2'd3
  } exc_state_t;

  localparam logic [3:0] ESTATUS_NONE    = 4'b0000;
  localparam logic [3:0] ESTATUS_INVOP   = 4'b0010;
  localparam logic [3:0] ESTATUS_DFAULT  = 4'b1111;
  localparam logic       ESTATUS_IRQ_MSB = 1'b1;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest-index active request wins.
module irq_prio_enc #(
  parameter int N_IRQ = 4
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [2:0]       idx
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = 3'd0;
    // Scan downwards so the lowest active index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: IRQ pending latch, enable mask, fixed priority,
// Exc/ExcAck handshake, ELR capture and ERET return, with a sticky double-fault state.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int IRQ_EDGE = 1,
  parameter int PC_W     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             irq_en_we,
  input  logic [N_IRQ-1:0] irq_en_wdata,
  input  logic             not_an_instr,
  input  logic             eret,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             exc_ack,
  output logic             exc,
  output logic [3:0]       estatus,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [PC_W-1:0]  elr,
  output logic             in_handler
);

  exc_state_t       state, state_d;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] irq_en;
  logic [N_IRQ-1:0] irq_set;

  logic             exc_d;
  logic [3:0]       estatus_d;
  logic [N_IRQ-1:0] irq_ack_d;
  logic [PC_W-1:0]  elr_d;
  logic             in_handler_d;

  logic             req_valid;
  logic [2:0]       req_idx;

  assign irq_set = (IRQ_EDGE != 0) ? (irq & ~irq_prev) : irq;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req   (pending & irq_en),
    .valid (req_valid),
    .idx   (req_idx)
  );

  // Masked lines still latch; a new request beats the acknowledge clearing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
      irq_en   <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      irq_prev <= irq;
      pending  <= (pending & ~irq_ack) | irq_set;
      if (irq_en_we) irq_en <= irq_en_wdata;
    end
  end

  // During TAKE/HANDLER estatus holds the cause, so its low bits double as the serviced index.
  always_comb begin
    state_d      = state;
    exc_d        = exc;
    estatus_d    = estatus;
    irq_ack_d    = '0;
    elr_d        = elr;
    in_handler_d = in_handler;
    unique case (state)
      IDLE: begin
        if (not_an_instr) begin
          state_d   = TAKE;
          exc_d     = 1'b1;
          estatus_d = ESTATUS_INVOP;
          elr_d     = pc_in;
        end else if (req_valid) begin
          state_d   = TAKE;
          exc_d     = 1'b1;
          estatus_d = {ESTATUS_IRQ_MSB, req_idx};
          elr_d     = pc_in;
        end
      end
      TAKE: begin
        if (exc_ack) begin
          state_d      = HANDLER;
          exc_d        = 1'b0;
          in_handler_d = 1'b1;
          for (int i = 0; i < N_IRQ; i++) begin
            irq_ack_d[i] = (estatus[3] == ESTATUS_IRQ_MSB) && (estatus[2:0] == 3'(i));
          end
        end
      end
      HANDLER: begin
        if (not_an_instr) begin
          state_d   = FAULT;
          exc_d     = 1'b1;
          estatus_d = ESTATUS_DFAULT;
        end else if (eret) begin
          state_d      = IDLE;
          estatus_d    = ESTATUS_NONE;
          in_handler_d = 1'b0;
        end
      end
      FAULT: begin
        exc_d     = 1'b1;
        estatus_d = ESTATUS_DFAULT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      exc        <= 1'b0;
      estatus    <= ESTATUS_NONE;
      irq_ack    <= '0;
      elr        <= '0;
      in_handler <= 1'b0;
    end else begin
      state      <= state_d;
      exc        <= exc_d;
      estatus    <= estatus_d;
      irq_ack    <= irq_ack_d;
      elr        <= elr_d;
      in_handler <= in_handler_d;
    end
  end

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench: one edge-mode and one level-mode controller, driven step by step.
module tb_exc_irq_ctrl;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Edge-mode instance
  logic        reset, irq_en_we, not_an_instr, eret, exc_ack;
  logic [3:0]  irq, irq_en_wdata;
  logic [63:0] pc_in;
  logic        exc, in_handler;
  logic [3:0]  estatus, irq_ack;
  logic [63:0] elr;

  // Level-mode instance
  logic        reset_l, irq_en_we_l, not_an_instr_l, eret_l, exc_ack_l;
  logic [3:0]  irq_l, irq_en_wdata_l;
  logic [63:0] pc_in_l;
  logic        exc_l, in_handler_l;
  logic [3:0]  estatus_l, irq_ack_l;
  logic [63:0] elr_l;

  always #5 clk = ~clk;

  exc_irq_ctrl #(.N_IRQ(4), .IRQ_EDGE(1), .PC_W(64)) dut_e (
    .clk(clk), .reset(reset), .irq(irq), .irq_en_we(irq_en_we), .irq_en_wdata(irq_en_wdata),
    .not_an_instr(not_an_instr), .eret(eret), .pc_in(pc_in), .exc_ack(exc_ack),
    .exc(exc), .estatus(estatus), .irq_ack(irq_ack), .elr(elr), .in_handler(in_handler)
  );

  exc_irq_ctrl #(.N_IRQ(4), .IRQ_EDGE(0), .PC_W(64)) dut_l (
    .clk(clk), .reset(reset_l), .irq(irq_l), .irq_en_we(irq_en_we_l), .irq_en_wdata(irq_en_wdata_l),
    .not_an_instr(not_an_instr_l), .eret(eret_l), .pc_in(pc_in_l), .exc_ack(exc_ack_l),
    .exc(exc_l), .estatus(estatus_l), .irq_ack(irq_ack_l), .elr(elr_l), .in_handler(in_handler_l)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; irq = '0; irq_en_we = 1'b0; irq_en_wdata = '0;
    not_an_instr = 1'b0; eret = 1'b0; exc_ack = 1'b0; pc_in = '0;
    reset_l = 1'b0; irq_l = '0; irq_en_we_l = 1'b0; irq_en_wdata_l = '0;
    not_an_instr_l = 1'b0; eret_l = 1'b0; exc_ack_l = 1'b0; pc_in_l = 64'h100;
    tick(); tick();
    check("rst_exc", 64'(exc), 64'(0));
    check("rst_estatus", 64'(estatus), 64'(0));
    check("rst_irq_ack", 64'(irq_ack), 64'(0));
    check("rst_elr", elr, 64'h0);
    check("rst_in_handler", 64'(in_handler), 64'(0));
    reset = 1'b1; reset_l = 1'b1;
    tick();

    // Single IRQ on line 2: pending after edge k, exc after edge k+1
    pc_in = 64'h40; irq = 4'b0100;
    tick();
    check("t1_no_exc_yet", 64'(exc), 64'(0));
    irq = 4'b0000;
    tick();
    check("t1_exc", 64'(exc), 64'(1));
    check("t1_estatus", 64'(estatus), 64'(4'b1010));
    check("t1_elr", elr, 64'h40);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check("t1_irq_ack", 64'(irq_ack), 64'(4'b0100));
    check("t1_exc_low", 64'(exc), 64'(0));
    check("t1_in_handler", 64'(in_handler), 64'(1));
    tick();
    check("t1_irq_ack_1cyc", 64'(irq_ack), 64'(0));
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t1_eret_estatus", 64'(estatus), 64'(0));
    check("t1_eret_in_handler", 64'(in_handler), 64'(0));

    // Lines 1 and 3 together: 1 first, then 3 after a one-cycle IDLE
    irq = 4'b1010;
    tick();
    irq = 4'b0000;
    tick();
    check("t2_first_estatus", 64'(estatus), 64'(4'b1001));
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check("t2_irq_ack", 64'(irq_ack), 64'(4'b0010));
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t2_idle_exc", 64'(exc), 64'(0));
    check("t2_idle_estatus", 64'(estatus), 64'(0));
    tick();
    check("t2_second_exc", 64'(exc), 64'(1));
    check("t2_second_estatus", 64'(estatus), 64'(4'b1011));
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    check("t2_quiet", 64'(exc), 64'(0));

    // NotAnInstr beats a pending IRQ 0, which stays pending
    irq = 4'b0001;
    tick();
    irq = 4'b0000; not_an_instr = 1'b1; pc_in = 64'h80;
    tick();
    not_an_instr = 1'b0;
    check("t3_estatus", 64'(estatus), 64'(4'b0010));
    check("t3_elr", elr, 64'h80);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check("t3_no_irq_ack", 64'(irq_ack), 64'(0));
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    check("t3_irq0_taken", 64'(estatus), 64'(4'b1000));
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();

    // Masked line latches but does not fire until enabled
    irq_en_we = 1'b1; irq_en_wdata = 4'b1110;
    tick();
    irq_en_we = 1'b0;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    tick(); tick();
    check("t4_masked_no_exc", 64'(exc), 64'(0));
    irq_en_we = 1'b1; irq_en_wdata = 4'b1111;
    tick();
    irq_en_we = 1'b0;
    check("t4_mask_write_edge", 64'(exc), 64'(0));
    tick();
    check("t4_unmasked_exc", 64'(exc), 64'(1));
    check("t4_estatus", 64'(estatus), 64'(4'b1000));

    // Double fault from HANDLER is sticky until reset
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    not_an_instr = 1'b1;
    tick();
    not_an_instr = 1'b0;
    check("t5_fault_exc", 64'(exc), 64'(1));
    check("t5_fault_estatus", 64'(estatus), 64'(4'b1111));
    eret = 1'b1; exc_ack = 1'b1; irq = 4'b0010;
    tick();
    eret = 1'b0; exc_ack = 1'b0; irq = 4'b0000;
    tick();
    check("t5_sticky_exc", 64'(exc), 64'(1));
    check("t5_sticky_estatus", 64'(estatus), 64'(4'b1111));
    check("t5_sticky_irq_ack", 64'(irq_ack), 64'(0));
    #2 reset = 1'b0;
    #1;
    check("t5_rst_exc", 64'(exc), 64'(0));
    check("t5_rst_estatus", 64'(estatus), 64'(0));
    check("t5_rst_elr", elr, 64'h0);
    check("t5_rst_in_handler", 64'(in_handler), 64'(0));
    tick();
    reset = 1'b1;

    // Level mode: held line re-sets pending through the acknowledge
    irq_l = 4'b0010;
    tick();
    tick();
    check("l_exc", 64'(exc_l), 64'(1));
    check("l_estatus", 64'(estatus_l), 64'(4'b1001));
    check("l_elr", elr_l, 64'h100);
    exc_ack_l = 1'b1;
    tick();
    exc_ack_l = 1'b0;
    check("l_irq_ack", 64'(irq_ack_l), 64'(4'b0010));
    tick();
    irq_l = 4'b0000; eret_l = 1'b1;
    tick();
    eret_l = 1'b0;
    check("l_idle", 64'(exc_l), 64'(0));
    tick();
    check("l_second_exc", 64'(exc_l), 64'(1));
    check("l_second_estatus", 64'(estatus_l), 64'(4'b1001));
    #2 reset_l = 1'b0;
    #1;
    check("l_rst_exc", 64'(exc_l), 64'(0));
    check("l_rst_estatus", 64'(estatus_l), 64'(0));
    tick();
    reset_l = 1'b1;
    tick(); tick();
    check("l_pending_lost", 64'(exc_l), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
